regfile_dumper: RTL and testbench
=================================

REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The module SHALL have parameter NUM_REGS, default 32, giving the number of registers dumped (range 1..32).
REQ-002 The module SHALL have parameter HEADER, default 8'hA5, giving the frame start byte.
REQ-003 The module SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-004 The module SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have start  input  1  dump request, sampled in IDLE only.
REQ-006 The module SHALL have rf_raddr  output  5  register file read address.
REQ-007 The module SHALL have rf_rdata  input  32  register file read data, combinational from rf_raddr in the same cycle.
REQ-008 The module SHALL have out_valid  output  1  byte stream valid.
REQ-009 The module SHALL have out_ready  input  1  byte stream ready from the sink.
REQ-010 The module SHALL have out_data  output  8  byte stream data.
REQ-011 The module SHALL have out_last  output  1  high with the final byte of a frame.
REQ-012 The module SHALL have busy  output  1  high in every state except IDLE.
REQ-013 The module SHALL have done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 The FSM SHALL have the states IDLE, HDR, LOAD, SEND and FIN.
REQ-015 IDLE: if start=1, next state SHALL be HDR, the register index SHALL clear to 0 and the byte count SHALL clear to 0.
REQ-016 HDR: out_valid=1 and out_data=HEADER; on out_valid&out_ready the FSM SHALL go to LOAD.
REQ-017 LOAD: rf_raddr=index and rf_rdata SHALL be captured into a 32-bit shift register; next state SHALL be SEND with out_valid=0 during LOAD.
REQ-018 SEND: out_valid=1 and out_data=shift[31:24], so each register goes out MSB byte first.
REQ-019 SEND handshake: each handshake SHALL shift left by 8 and increment the byte count (mod 4).
REQ-020 After the 4th byte of a register, if index==NUM_REGS-1 the FSM SHALL go to FIN; otherwise the index SHALL increment, the byte count SHALL return to 0 and the FSM SHALL go to LOAD.
REQ-021 FIN: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 out_last SHALL be 1 only in SEND with index==NUM_REGS-1 and byte count==3.
REQ-023 With out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable and the state SHALL not advance.
REQ-024 out_valid SHALL not depend combinationally on out_ready.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-026 The frame length SHALL be 1+4*NUM_REGS bytes; the default frame is 129 bytes.
REQ-027 With out_ready held at 1, start at cycle T SHALL produce HDR at T+1 and done at T+2+5*NUM_REGS, which is T+162 for the default.
REQ-028 Each register value SHALL be sampled in its own LOAD cycle, so writes to other registers during the dump are not snapshotted atomically.
REQ-029 Register 0 SHALL be dumped as whatever rf_rdata returns for address 0, with no special-casing.
REQ-030 rf_raddr SHALL equal the current index in every state and SHALL be 0 in IDLE.

Reset
REQ-031 When rst=1 at posedge clk, the state SHALL become IDLE and index, byte count and shift register SHALL become 0.
REQ-032 During and after reset, out_valid, out_last, busy and done SHALL be 0, out_data SHALL be 8'h00 and rf_raddr SHALL be 5'd0.
REQ-033 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-034 Reset mid-frame SHALL abort the frame with no out_last and no done; the next start SHALL begin again with HEADER.

Verification
REQ-035 Regfile model with reg[i]=32'h01000000*i+i, out_ready=1, start pulse: the bench SHALL check HEADER A5, then bytes 00 00 00 00, 01 00 00 01 ... 1F 00 00 1F, out_last on byte 129, and done 162 cycles after start.
REQ-036 Random out_ready (50% duty) with the same frame: the bench SHALL check an identical 129-byte sequence and that out_data is stable whenever valid=1 and ready=0.
REQ-037 start pulsed at cycles 10 and 50 after the first start: the bench SHALL check that exactly one frame and one done pulse are produced.
REQ-038 rst asserted 1 cycle during the 40th byte: the bench SHALL check that busy=0, out_valid=0 and rf_raddr=0 the next cycle, with no done; a following start SHALL produce a full frame beginning A5.
REQ-039 NUM_REGS=1 with reg0 model returning 32'hDEADBEEF: the bench SHALL check the frame A5 DE AD BE EF with out_last on EF.
REQ-040 Model writes reg[31]=32'hCAFEF00D while index<31: the bench SHALL check that the last four bytes are CA FE F0 0D.

Source files
------------

// File: rtl/regfile_dumper.sv
// regfile_dumper: streams a register file as a byte frame: HEADER, then each register MSB byte first
module regfile_dumper #(
    parameter int         NUM_REGS = 32,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, FIN} state_t;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
    state_t      r_state, w_next;
    logic [4:0]  r_idx;
    logic [1:0]  r_cnt;
    logic [31:0] r_shift;
    logic        w_last_reg;
    logic        w_reg_end;
    assign w_last_reg = r_idx == LAST_IDX;
    assign w_reg_end  = r_cnt == 2'd3;
    // next state and Moore outputs; out_valid never looks at out_ready
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rf_raddr  = r_idx;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                rf_raddr = 5'd0;
                w_next   = start ? HDR : IDLE;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = HEADER;
                w_next    = out_ready ? LOAD : HDR;
            end
            LOAD: w_next = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_data  = r_shift[31:24];
                out_last  = w_last_reg && w_reg_end;
                w_next    = !(out_ready && w_reg_end) ? SEND : (w_last_reg ? FIN : LOAD);
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // register index, byte counter and the byte shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 5'd0;
            r_cnt   <= 2'd0;
            r_shift <= 32'd0;
        end else if (r_state == IDLE && start) begin
            r_idx <= 5'd0;
            r_cnt <= 2'd0;
        end else if (r_state == LOAD) begin
            r_shift <= rf_rdata;
        end else if (r_state == SEND && out_ready) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_cnt   <= r_cnt + 2'd1;
            if (w_reg_end && !w_last_reg) r_idx <= r_idx + 5'd1;
        end
    end
endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: scoreboard bench for the register file dumper
module tb_regfile_dumper;
    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        out_valid, out_last, busy, done;
    logic [7:0]  out_data;
    logic        start2;
    logic [4:0]  rf_raddr2;
    logic        out_valid2, out_last2, busy2, done2;
    logic [7:0]  out_data2;
    logic [31:0] regs [32];
    logic [7:0]  q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rf_rdata = regs[rf_raddr];

    regfile_dumper dut (
        .clk(clk), .rst(rst), .start(start), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dumper #(.NUM_REGS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .rf_raddr(rf_raddr2), .rf_rdata(32'hDEADBEEF),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .out_last(out_last2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // rnd: random ready; dbl: extra starts at k=10,50; wr31: rewrite reg31 mid-dump; abort_at: reset on that byte
    task automatic run_frame(input bit rnd, input bit dbl, input bit wr31, input int abort_at);
        logic [31:0] v;
        logic [7:0]  e, pd;
        logic        pl;
        int          k, nb, dones, extra;
        bit          stall, fin;
        q.delete();
        q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) begin
            v = (wr31 && i == 31) ? 32'hCAFEF00D : regs[i];
            for (int b = 3; b >= 0; b--) q.push_back(v[b*8 +: 8]);
        end
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        k = 0; nb = 0; dones = 0; extra = 0; stall = 0; fin = 0; pd = 8'h00; pl = 1'b0;
        while (!fin && k < 3000) begin
            @(negedge clk);
            k++;
            start = dbl && (k == 10 || k == 50);
            if (wr31 && k == 50) regs[31] = 32'hCAFEF00D;
            if (k == 1) check("hdr_busy", {31'd0, busy}, 1);
            if (stall) begin
                check("stall_valid", {31'd0, out_valid}, 1);
                check("stall_data", {24'd0, out_data}, {24'd0, pd});
                check("stall_last", {31'd0, out_last}, {31'd0, pl});
            end
            if (done) begin
                dones++;
                fin = 1;
                if (!rnd) check("done_latency", k, 2 + 5 * 32);
                check("done_bytes", nb, 129);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && nb + 1 == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", {31'd0, busy}, 0);
                check("abort_valid", {31'd0, out_valid}, 0);
                check("abort_raddr", {27'd0, rf_raddr}, 0);
                check("abort_done", {31'd0, done}, 0);
                repeat (20) begin
                    @(negedge clk);
                    if (done || out_valid) extra++;
                end
                check("abort_quiet", extra, 0);
                q.delete();
                return;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (out_valid && out_ready) begin
                nb++;
                if (q.size() == 0) check("extra_byte", nb, 129);
                else begin
                    e = q.pop_front();
                    check("byte", {24'd0, out_data}, {24'd0, e});
                    check("last", {31'd0, out_last}, {31'd0, q.size() == 0});
                end
            end
        end
        check("finished", {31'd0, fin}, 1);
        check("queue_empty", q.size(), 0);
        repeat (dbl ? 120 : 5) begin
            @(negedge clk);
            if (done) dones++;
            if (out_valid || busy) extra++;
        end
        check("done_count", dones, 1);
        check("idle_quiet", extra, 0);
        check("idle_raddr", {27'd0, rf_raddr}, 0);
        regs[31] = 32'h1F00001F;
    endtask

    initial begin
        logic [7:0] e;
        int         k;
        bit         fin;
        for (int i = 0; i < 32; i++) regs[i] = 32'h01000000 * i + i;
        rst = 1'b1; start = 1'b1; start2 = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_last", {31'd0, out_last}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_data", {24'd0, out_data}, 0);
        check("rst_raddr", {27'd0, rf_raddr}, 0);
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);
        run_frame(0, 0, 0, 0);
        run_frame(1, 0, 0, 0);
        run_frame(0, 1, 0, 0);
        run_frame(0, 0, 0, 40);
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 1, 0);
        q.delete();
        q.push_back(8'hA5); q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
        @(negedge clk);
        start2 = 1'b1;
        k = 0; fin = 0;
        while (!fin && k < 100) begin
            @(negedge clk);
            k++;
            start2 = 1'b0;
            if (done2) begin
                fin = 1;
                check("n1_latency", k, 7);
                check("n1_queue", q.size(), 0);
            end
            if (out_valid2) begin
                if (q.size() == 0) check("n1_extra", {24'd0, out_data2}, 0);
                else begin
                    e = q.pop_front();
                    check("n1_byte", {24'd0, out_data2}, {24'd0, e});
                    check("n1_last", {31'd0, out_last2}, {31'd0, q.size() == 0});
                end
            end
        end
        check("n1_finished", {31'd0, fin}, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
